// File: rtl/shifter_base3_pipe.sv
// Pipelined barrel shifter with a base-3 shift amount: stage k resolves ternary digit k (weight 3^k).
// Define SHIFTER_STICKY_EN to add out_sticky, the OR of every bit shifted out along the way.
`timescale 1ns/1ps

module shifter_base3_pipe #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [2*DIGITS-1:0]   in_shamt,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
`ifdef SHIFTER_STICKY_EN
  ,
  output logic                  out_sticky
`endif
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  function automatic int unsigned pow3(input int k);
    int unsigned p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 3;
    return p;
  endfunction

  // Amounts of WIDTH or more fall out naturally: logical shifts give 0, SRA gives sign copies.
  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] d, input mode_e mode,
                                                input int unsigned amt);
    logic [WIDTH-1:0] r;
    int unsigned      rot;
    rot = amt % WIDTH;
    case (mode)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = $signed(d) >>> amt;
      default:  r = (d >> rot) | (d << (WIDTH - rot));
    endcase
    return r;
  endfunction

`ifdef SHIFTER_STICKY_EN
  function automatic logic shifted_out(input logic [WIDTH-1:0] d, input mode_e mode,
                                       input int unsigned amt);
    logic s;
    case (mode)
      MODE_SLL: s = |(d & ~({WIDTH{1'b1}} >> amt));
      MODE_SRL,
      MODE_SRA: s = |(d & ~({WIDTH{1'b1}} << amt));
      default:  s = 1'b0;
    endcase
    return s;
  endfunction
`endif

  logic                valid_q [DIGITS];
  logic                valid_d [DIGITS];
  logic [WIDTH-1:0]    data_q  [DIGITS];
  logic [WIDTH-1:0]    data_d  [DIGITS];
  mode_e               mode_q  [DIGITS];
  mode_e               mode_d  [DIGITS];
  logic [2*DIGITS-1:0] shamt_q [DIGITS];
  logic [2*DIGITS-1:0] shamt_d [DIGITS];
  logic                err_q   [DIGITS];
  logic                err_d   [DIGITS];

  logic                src_valid [DIGITS];
  logic [WIDTH-1:0]    src_data  [DIGITS];
  mode_e               src_mode  [DIGITS];
  logic [2*DIGITS-1:0] src_shamt [DIGITS];
  logic                src_err   [DIGITS];
  logic [1:0]          digit     [DIGITS];
  int unsigned         amt       [DIGITS];
`ifdef SHIFTER_STICKY_EN
  logic                sticky_q   [DIGITS];
  logic                sticky_d   [DIGITS];
  logic                src_sticky [DIGITS];
`endif

  logic advance;

  // One global stall: the whole pipe moves only when the output slot is free or being taken.
  assign advance  = !valid_q[DIGITS-1] || out_ready;
  assign in_ready = advance;

  // Each stage consumes the lowest remaining digit and forwards the rest shifted down.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_mode[0]  = mode_e'(in_mode);
    src_shamt[0] = in_shamt;
    src_err[0]   = 1'b0;
`ifdef SHIFTER_STICKY_EN
    src_sticky[0] = 1'b0;
`endif
    for (int k = 1; k < DIGITS; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_err[k]   = err_q[k-1];
`ifdef SHIFTER_STICKY_EN
      src_sticky[k] = sticky_q[k-1];
`endif
    end
    for (int k = 0; k < DIGITS; k++) begin
      digit[k]   = src_shamt[k][1:0];
      amt[k]     = (digit[k] == 2'b11) ? 32'd0 : 32'(digit[k]) * pow3(k);
      valid_d[k] = src_valid[k];
      mode_d[k]  = src_mode[k];
      data_d[k]  = shift_op(src_data[k], src_mode[k], amt[k]);
      shamt_d[k] = src_shamt[k] >> 2;
      err_d[k]   = src_err[k] || (digit[k] == 2'b11);
`ifdef SHIFTER_STICKY_EN
      sticky_d[k] = src_sticky[k] || shifted_out(src_data[k], src_mode[k], amt[k]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIGITS; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        mode_q[k]  <= MODE_SLL;
        shamt_q[k] <= '0;
        err_q[k]   <= 1'b0;
`ifdef SHIFTER_STICKY_EN
        sticky_q[k] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int k = 0; k < DIGITS; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        mode_q[k]  <= mode_d[k];
        shamt_q[k] <= shamt_d[k];
        err_q[k]   <= err_d[k];
`ifdef SHIFTER_STICKY_EN
        sticky_q[k] <= sticky_d[k];
`endif
      end
    end
  end

  assign out_valid = valid_q[DIGITS-1];
  assign out_data  = data_q[DIGITS-1];
  assign out_err   = err_q[DIGITS-1];
`ifdef SHIFTER_STICKY_EN
  assign out_sticky = sticky_q[DIGITS-1];
`endif

endmodule

// File: tb/tb_shifter_base3_pipe.sv
// Self-checking bench for shifter_base3_pipe: directed cases, backpressure, reset in flight and random traffic.
// Honours SHIFTER_STICKY_EN the same way the design does.
`timescale 1ns/1ps

module tb_shifter_base3_pipe;

  localparam int W = 16;
  localparam int D = 3;
  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [2*D-1:0] in_shamt;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
`ifdef SHIFTER_STICKY_EN
  logic           out_sticky;
`endif

  shifter_base3_pipe #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef SHIFTER_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
    logic         sticky;
  } exp_t;

  exp_t exp_q[$];
  exp_t popped;
  int   checks   = 0;
  int   errors   = 0;
  int   received = 0;
  logic send_done;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: total amount from legal digits, then each result bit picked from its source position.
  function automatic exp_t model(input logic [W-1:0] d, input logic [2*D-1:0] s, input logic [1:0] m);
    exp_t e;
    int   total;
    int   weight;
    int   src;
    e      = '0;
    total  = 0;
    weight = 1;
    for (int k = 0; k < D; k++) begin
      if (s[2*k +: 2] == 2'b11) e.err = 1'b1;
      else total += int'(s[2*k +: 2]) * weight;
      weight *= 3;
    end
    for (int i = 0; i < W; i++) begin
      case (m)
        SLL: begin
          src = i - total;
          if (src >= 0) e.data[i] = d[src];
          if (i + total >= W) e.sticky |= d[i];
        end
        SRL, SRA: begin
          src = i + total;
          if (src < W) e.data[i] = d[src];
          else if (m == SRA) e.data[i] = d[W-1];
          if (i < total) e.sticky |= d[i];
        end
        default: e.data[i] = d[(i + total) % W];
      endcase
    end
    return e;
  endfunction

  function automatic logic [2*D-1:0] rand_shamt();
    logic [2*D-1:0] s;
    int r;
    for (int k = 0; k < D; k++) begin
      r = $urandom_range(0, 9);
      s[2*k +: 2] = (r == 0) ? 2'b11 : 2'(r % 3);
    end
    return s;
  endfunction

  // Scoreboard: every cycle with out_valid high must show the oldest accepted request's result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          check_output("out_data", 32'(out_data), 32'(exp_q[0].data));
          check_output("out_err", 32'(out_err), 32'(exp_q[0].err));
`ifdef SHIFTER_STICKY_EN
          check_output("out_sticky", 32'(out_sticky), 32'(exp_q[0].sticky));
`endif
          if (out_ready) begin
            popped = exp_q.pop_front();
            received++;
          end
        end
      end
      check_output("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt, in_mode));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic apply_stimulus(input logic [W-1:0] d, input logic [2*D-1:0] s, input logic [1:0] m);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_output("drain_in_time", 32'(g < 200), 32'd1);
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] d, input logic [2*D-1:0] s,
                              input logic [1:0] m, input logic [W-1:0] exp_data, input logic exp_err,
                              input logic exp_sticky);
    int lat;
    wait_drain();
    $display("[TB] %s: expecting data 0x%0h err %0b sticky %0b", name, exp_data, exp_err, exp_sticky);
    apply_stimulus(d, s, m);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({name, "_latency"}, 32'(lat), 32'(D));
    check_output({name, "_data"}, 32'(out_data), 32'(exp_data));
    check_output({name, "_err"}, 32'(out_err), 32'(exp_err));
`ifdef SHIFTER_STICKY_EN
    check_output({name, "_sticky"}, 32'(out_sticky), 32'(exp_sticky));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   rec0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = SLL;
    out_ready = 1'b1;
    send_done = 1'b0;

    e = model(16'h8000, 6'b010000, SRA);
    check_output("model_sra9", 32'(e.data), 32'h0000_FFC0);
    e = model(16'h0001, 6'b011010, ROR);
    check_output("model_ror17", 32'(e.data), 32'h0000_8000);
    e = model(16'h0003, 6'b101010, SRL);
    check_output("model_srl26_sticky", 32'(e.sticky), 32'd1);
    e = model(16'h1234, 6'b000011, SRL);
    check_output("model_illegal", {15'd0, e.err, e.data}, {15'd0, 1'b1, 16'h1234});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_data", 32'(out_data), 32'd0);
    check_output("reset_out_err", 32'(out_err), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_STICKY_EN
    check_output("reset_out_sticky", 32'(out_sticky), 32'd0);
`endif

    run_directed("sra9", 16'h8000, 6'b010000, SRA, 16'hFFC0, 1'b0, 1'b0);
    run_directed("ror17", 16'h0001, 6'b011010, ROR, 16'h8000, 1'b0, 1'b0);
    run_directed("sll26", 16'h00FF, 6'b101010, SLL, 16'h0000, 1'b0, 1'b1);
    run_directed("sra26", 16'h8001, 6'b101010, SRA, 16'hFFFF, 1'b0, 1'b1);
    run_directed("srl26", 16'h0003, 6'b101010, SRL, 16'h0000, 1'b0, 1'b1);
    run_directed("illegal", 16'h1234, 6'b000011, SRL, 16'h1234, 1'b1, 1'b0);
    run_directed("after_illegal", 16'h0001, 6'b000001, SLL, 16'h0002, 1'b0, 1'b0);

    // Six back-to-back requests with the consumer stalled for five cycles once results appear.
    wait_drain();
    rec0      = received;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          apply_stimulus(16'hA5C3 ^ 16'(i * 16'h1111), 6'(5 + i * 4), 2'(i));
      end
      begin
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        check_output("bp_out_valid_rise", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
          check_output("bp_in_ready_low", 32'(in_ready), 32'd0);
          check_output("bp_out_valid_held", 32'(out_valid), 32'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_output("bp_result_count", 32'(received - rec0), 32'd6);

    // Reset with two requests still inside the pipe: neither may ever reach the output.
    apply_stimulus(16'h0F0F, 6'b010101, SRL);
    apply_stimulus(16'hF0F0, 6'b000110, SLL);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_flight_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_flight_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < D + 2; c++) begin
      @(posedge clk);
      #1;
      check_output("rst_flight_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic with random input gaps and random consumer stalls.
    rec0 = received;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          apply_stimulus(16'($urandom), rand_shamt(), 2'($urandom_range(0, 3)));
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    wait_drain();
    check_output("rand_result_count", 32'(received - rec0), 32'd250);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_base3_pipe.md
Name: shifter_base3_pipe

Overview:
Parametrised, pipelined, multi-mode barrel shifter. The shift amount is base-3 encoded, two bits per ternary digit. Each ternary digit k is resolved in its own registered stage, which shifts by d_k*3^k. Valid/ready handshake on both sides. Used by the ALU/execute path when shift latency can be traded for cycle time, and by wide-datapath variants beyond 16 bits.

Parameters:
WIDTH, 16, data width in bits (>=2)
DIGITS, 3, number of base-3 digits and pipeline stages; max encodable shift 3^DIGITS-1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept request this cycle
in_data  input  WIDTH  operand
in_shamt  input  2*DIGITS  base-3 shift amount; bits [2k+1:2k] = digit k (00=0, 01=1, 10=2, 11=illegal)
in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_err  output  1  at least one digit of this request was 11

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high.
- Reset values: all stage valid bits = 0, out_valid = 0, out_data = 0, out_err = 0. in_ready = 1 in the cycle after reset.
- Pipeline structure: DIGITS register stages. Stage k holds data, mode, remaining digits, err and valid. Stage k applies digit k. The last stage drives the out_* ports directly from its registers.
- Stall: global. advance = !out_valid | out_ready.
- in_ready = advance. This is combinational from out_valid and out_ready only.
- When advance = 1, every stage loads from the previous stage, and stage 0 loads the input. A bubble enters when in_valid = 0.
- When advance = 0, every stage holds.
- Latency: DIGITS cycles from acceptance to out_valid, when there is no backpressure. Throughput: 1 per cycle. Ordering is preserved. Capacity is DIGITS requests.
- Per-stage shift, stage k, weight w = 3^k, digit d:
  - SLL: left shift by d*w, zero fill.
  - SRL: right shift by d*w, zero fill.
  - SRA: right shift by d*w, fill with bit WIDTH-1.
  - ROR: rotate right by (d*w) mod WIDTH.
- Shift amount >= WIDTH, total or per stage:
  - SLL and SRL give 0.
  - SRA gives all copies of the sign bit.
  - ROR wraps naturally as the sum of per-stage rotations mod WIDTH.
- Illegal digit 11: that stage shifts by 0, and the request's err bit is set and carried to out_err. Other digits still apply.
- Result constraint: out_data for a legal shamt equals the reference op applied with amount = sum d_k*3^k.
- Output stability: out_data and out_err are stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all in-flight requests are discarded and no partial result is emitted.

Optional Feature:
SHIFTER_STICKY_EN
- Defined:
  - Adds output port out_sticky (1 bit), registered with the data through every stage.
  - out_sticky is the OR of every bit discarded across all stages: low bits for SRL/SRA, high bits for SLL.
  - out_sticky is always 0 for ROR.
  - Resets to 0.
- Undefined: the port is absent and no extra flops are built.

Test Plan:
1. Arithmetic shift by 9: WIDTH=16. SRA in_data=0x8000, shamt=6'b010000 (9) → out_valid exactly 3 cycles after acceptance, out_data=0xFFC0, out_err=0.
2. Rotate by 17: ROR in_data=0x0001, shamt=6'b011010 (17) → out_data=0x8000. With SHIFTER_STICKY_EN, out_sticky=0.
3. Maximum shift, three cases with shamt=6'b101010 (26):
   - SLL 0x00FF → 0x0000.
   - SRA 0x8001 → 0xFFFF.
   - SRL 0x0003 → 0x0000, with out_sticky=1 when SHIFTER_STICKY_EN is defined.
4. Backpressure: 6 back-to-back requests, with out_ready held low 5 cycles once out_valid rises.
   - in_ready = 0 while stalled.
   - Outputs hold steady.
   - All 6 results arrive in order, with no loss or duplication.
5. Illegal digit: SRL in_data=0x1234, shamt=6'b000011 → out_data=0x1234, out_err=1. The next legal request has out_err=0.
6. Reset in flight: assert rst for 1 cycle with 2 requests in flight → next cycle out_valid=0, in_ready=1. No stale result ever appears.
